// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the writeback stage.
//   CPU_W      : default data path width
//   CPU_A      : default register address width
//   wb_entry_t : one pending register write (valid, destination, data)
package cpu_pkg;
  localparam int CPU_W = 8;
  localparam int CPU_A = 4;

  typedef struct packed {
    logic             valid;
    logic [CPU_A-1:0] dest;
    logic [CPU_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fwd_mux.sv
// Single read-port forwarding select.
// Picks the youngest copy of the register addressed by raddr_i:
// skid entry, then the output register (write in flight), then the RegFile.
//   skid_vld_i/skid_dest_i/skid_data_i : pending skid entry
//   out_vld_i/out_dest_i/out_data_i    : registered write port contents
//   raddr_i                            : operand address
//   rf_data_i                          : RegFile read data for raddr_i
//   fwd_o                              : forwarded operand (combinational)
module wb_fwd_mux #(
  parameter int W = 8,
  parameter int A = 4
) (
  input  logic         skid_vld_i,
  input  logic [A-1:0] skid_dest_i,
  input  logic [W-1:0] skid_data_i,
  input  logic         out_vld_i,
  input  logic [A-1:0] out_dest_i,
  input  logic [W-1:0] out_data_i,
  input  logic [A-1:0] raddr_i,
  input  logic [W-1:0] rf_data_i,
  output logic [W-1:0] fwd_o
);
  always_comb begin
    fwd_o = rf_data_i;
    if (skid_vld_i && (skid_dest_i == raddr_i))
      fwd_o = skid_data_i;
    else if (out_vld_i && (out_dest_i == raddr_i))
      fwd_o = out_data_i;
  end
endmodule

// File: rtl/reg_writeback.sv
// Writeback stage feeding the RegFile write port.
// Merges ALU results and load responses into one registered write port,
// with a 1-entry skid buffer absorbing ALU/load collisions, and forwards
// not-yet-committed results onto both read operands.
//   Clk, Reset                 : clock, synchronous active-low reset
//   AluValid/AluDest/AluData   : ALU result (held by execute while Stall=1)
//   MemValid/MemDest/MemData   : load response, never stalled
//   Stall                      : skid occupied, ALU result not accepted
//   WriteEn/Waddr/DataIn       : registered RegFile write port
//   RaddrA/B, DataOutA/B       : RegFile read addresses and data
//   FwdA/FwdB                  : forwarded operands
module reg_writeback
  import cpu_pkg::*;
#(
  parameter int W = CPU_W,
  parameter int A = CPU_A
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         AluValid,
  input  logic [A-1:0] AluDest,
  input  logic [W-1:0] AluData,
  input  logic         MemValid,
  input  logic [A-1:0] MemDest,
  input  logic [W-1:0] MemData,
  output logic         Stall,
  output logic         WriteEn,
  output logic [A-1:0] Waddr,
  output logic [W-1:0] DataIn,
  input  logic [A-1:0] RaddrA,
  input  logic [A-1:0] RaddrB,
  input  logic [W-1:0] DataOutA,
  input  logic [W-1:0] DataOutB,
  output logic [W-1:0] FwdA,
  output logic [W-1:0] FwdB
);
  wb_entry_t skid_q, skid_d;
  wb_entry_t out_q, out_d;
  logic      alu_acc;

  // Stall is purely flop-derived so execute sees no input-to-output path.
  assign Stall   = skid_q.valid;
  assign WriteEn = out_q.valid;
  assign Waddr   = out_q.dest;
  assign DataIn  = out_q.data;

  always_comb begin
    alu_acc = AluValid & ~skid_q.valid;
    skid_d  = skid_q;
    out_d   = out_q;
    out_d.valid = 1'b0;
    if (MemValid) begin
      out_d = '{valid: 1'b1, dest: MemDest, data: MemData};
      // A load to the skid's register is younger than the skid entry,
      // so the skid result is dead and is dropped rather than written.
      if (skid_q.valid && (skid_q.dest == MemDest))
        skid_d.valid = 1'b0;
      else if (alu_acc)
        skid_d = '{valid: 1'b1, dest: AluDest, data: AluData};
    end else if (skid_q.valid) begin
      out_d        = skid_q;
      skid_d.valid = 1'b0;
    end else if (alu_acc) begin
      out_d = '{valid: 1'b1, dest: AluDest, data: AluData};
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      skid_q <= '0;
      out_q  <= '0;
    end else begin
      skid_q <= skid_d;
      out_q  <= out_d;
    end
  end

  wb_fwd_mux #(.W(W), .A(A)) u_fwd_a (
    .skid_vld_i (skid_q.valid),
    .skid_dest_i(skid_q.dest),
    .skid_data_i(skid_q.data),
    .out_vld_i  (out_q.valid),
    .out_dest_i (out_q.dest),
    .out_data_i (out_q.data),
    .raddr_i    (RaddrA),
    .rf_data_i  (DataOutA),
    .fwd_o      (FwdA)
  );

  wb_fwd_mux #(.W(W), .A(A)) u_fwd_b (
    .skid_vld_i (skid_q.valid),
    .skid_dest_i(skid_q.dest),
    .skid_data_i(skid_q.data),
    .out_vld_i  (out_q.valid),
    .out_dest_i (out_q.dest),
    .out_data_i (out_q.data),
    .raddr_i    (RaddrB),
    .rf_data_i  (DataOutB),
    .fwd_o      (FwdB)
  );
endmodule

// File: tb/tb_reg_writeback.sv
// Randomized scoreboard bench for reg_writeback. The bench plays the RegFile
// itself and keeps an abstract model: a list of pending results (at most one
// parked) plus the write currently in flight.
module tb_reg_writeback;
  logic       Clk = 1'b0;
  logic       Reset;
  logic       AluValid, MemValid;
  logic [3:0] AluDest, MemDest, RaddrA, RaddrB;
  logic [7:0] AluData, MemData, DataOutA, DataOutB;
  logic       Stall, WriteEn;
  logic [3:0] Waddr;
  logic [7:0] DataIn, FwdA, FwdB;

  always #5 Clk = ~Clk;

  reg_writeback dut (
    .Clk(Clk), .Reset(Reset),
    .AluValid(AluValid), .AluDest(AluDest), .AluData(AluData),
    .MemValid(MemValid), .MemDest(MemDest), .MemData(MemData),
    .Stall(Stall), .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn),
    .RaddrA(RaddrA), .RaddrB(RaddrB), .DataOutA(DataOutA), .DataOutB(DataOutB),
    .FwdA(FwdA), .FwdB(FwdB)
  );

  typedef struct {
    bit         v;
    logic [3:0] d;
    logic [7:0] x;
  } ent_t;
  typedef struct {
    logic [3:0] d;
    logic [7:0] x;
    int         due;
  } exp_t;

  logic [7:0] rf [16];
  ent_t       parked[$];   // result accepted but not yet sent to RegFile
  ent_t       cur_out, nxt_out;
  exp_t       sb[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  assign DataOutA = rf[RaddrA];
  assign DataOutB = rf[RaddrB];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_fwd(input logic [3:0] ra);
    foreach (parked[i]) if (parked[i].d == ra) return parked[i].x;
    if (cur_out.v && cur_out.d == ra) return cur_out.x;
    return rf[ra];
  endfunction

  // One clock cycle: commit, check stall, drive, check forwarding, predict.
  task automatic cycle(input bit rst_n, input bit av, input logic [3:0] ad, input logic [7:0] adat,
                       input bit mv, input logic [3:0] md, input logic [7:0] mdat,
                       input logic [3:0] ra, input logic [3:0] rb);
    bit   busy;
    exp_t e;
    @(posedge Clk); #1;
    cyc++;
    if (cur_out.v) rf[cur_out.d] = cur_out.x;
    cur_out = nxt_out;
    busy = (parked.size() != 0);
    chk("stall", {7'd0, Stall}, {7'd0, busy});
    Reset = rst_n; AluValid = av; AluDest = ad; AluData = adat;
    MemValid = mv; MemDest = md; MemData = mdat; RaddrA = ra; RaddrB = rb;
    #1;
    chk("fwdA", FwdA, exp_fwd(ra));
    chk("fwdB", FwdB, exp_fwd(rb));
    nxt_out = '{v: 1'b0, d: 4'd0, x: 8'd0};
    if (!rst_n) begin
      parked.delete();
    end else if (mv) begin
      // load always goes out now; it kills an older pending result to the same reg
      nxt_out = '{v: 1'b1, d: md, x: mdat};
      if (busy) begin
        if (parked[0].d == md) parked.delete();
      end else if (av) begin
        parked.push_back('{v: 1'b1, d: ad, x: adat});
      end
    end else if (busy) begin
      nxt_out = parked.pop_front();
    end else if (av) begin
      nxt_out = '{v: 1'b1, d: ad, x: adat};
    end
    if (nxt_out.v) begin
      e.d = nxt_out.d; e.x = nxt_out.x; e.due = cyc + 1;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input logic [3:0] ra, input logic [3:0] rb);
    cycle(1, 0, 4'd0, 8'd0, 0, 4'd0, 8'd0, ra, rb);
  endtask

  // Write-port monitor: every write must match the oldest expected one, on time.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk); #3;
      if (WriteEn !== 1'b0) begin
        checks++;
        if (WriteEn !== 1'b1 || sb.size() == 0) begin
          failures++;
          $display("FAIL write_unexpected cyc=%0d got we=%b addr=%h data=%h expected no write",
                   cyc, WriteEn, Waddr, DataIn);
        end else begin
          e = sb.pop_front();
          if (Waddr !== e.d || DataIn !== e.x || e.due != cyc) begin
            failures++;
            $display("FAIL write cyc=%0d got addr=%h data=%h expected addr=%h data=%h due=%0d",
                     cyc, Waddr, DataIn, e.d, e.x, e.due);
          end
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        checks++;
        failures++;
        e = sb.pop_front();
        $display("FAIL write_missing cyc=%0d got we=0 expected addr=%h data=%h", cyc, e.d, e.x);
      end
    end
  end

  initial begin
    bit         av, mv, rs;
    logic [3:0] ad, md;
    logic [7:0] adat, mdat;
    for (int i = 0; i < 16; i++) rf[i] = 8'hC0 + 8'(i);
    cur_out = '{v: 1'b0, d: 4'd0, x: 8'd0};
    nxt_out = cur_out;
    Reset = 1'b0; AluValid = 1'b1; AluDest = 4'd5; AluData = 8'h99;
    MemValid = 1'b0; MemDest = 4'd0; MemData = 8'd0; RaddrA = 4'd5; RaddrB = 4'd0;

    // reset held with ALU asserted: nothing accepted, no writes
    cycle(0, 1, 4'd5, 8'h99, 0, 4'd0, 8'd0, 4'd5, 4'd0);
    cycle(0, 1, 4'd5, 8'h99, 0, 4'd0, 8'd0, 4'd5, 4'd0);
    chk("rst_fwdA", FwdA, 8'hC5);
    // ALU write and forward from the output register
    cycle(1, 1, 4'd2, 8'h5A, 0, 4'd0, 8'd0, 4'd2, 4'd0);
    idle(4'd2, 4'd0);
    chk("t2_fwdA", FwdA, 8'h5A);
    chk("t2_oldrf", DataOutA, 8'hC2);
    // collision: load first, ALU parked then drained
    cycle(1, 1, 4'd3, 8'h33, 1, 4'd1, 8'h11, 4'd3, 4'd1);
    idle(4'd3, 4'd1);
    chk("t3_stall1", {7'd0, Stall}, 8'd1);
    idle(4'd3, 4'd1);
    chk("t3_stall0", {7'd0, Stall}, 8'd0);
    // younger load to the parked register drops the parked ALU value
    cycle(1, 1, 4'd3, 8'h33, 1, 4'd1, 8'h11, 4'd3, 4'd1);
    cycle(1, 0, 4'd0, 8'd0, 1, 4'd3, 8'h77, 4'd3, 4'd1);
    idle(4'd3, 4'd0);
    chk("t4_stall0", {7'd0, Stall}, 8'd0);
    chk("t4_fwdA", FwdA, 8'h77);
    // skid and output reg both hold reg 2: skid is younger
    cycle(1, 1, 4'd2, 8'hAA, 1, 4'd2, 8'hBB, 4'd0, 4'd2);
    idle(4'd0, 4'd2);
    chk("t5_fwdB", FwdB, 8'hAA);
    idle(4'd0, 4'd2);
    // reset with the skid full discards it
    cycle(1, 1, 4'd5, 8'h66, 1, 4'd4, 8'h44, 4'd5, 4'd4);
    cycle(0, 0, 4'd0, 8'd0, 0, 4'd0, 8'd0, 4'd5, 4'd4);
    idle(4'd5, 4'd4);
    chk("t6_stall0", {7'd0, Stall}, 8'd0);
    chk("t6_fwdA", FwdA, 8'hC5);

    // random traffic on a small address range to provoke hazards
    av = 0; ad = 0; adat = 0;
    for (int n = 0; n < 600; n++) begin
      if (!(av && parked.size() != 0)) begin  // execute holds while stalled
        av   = ($urandom_range(0, 99) < 60);
        ad   = 4'($urandom_range(0, 3));
        adat = 8'($urandom);
      end
      mv   = ($urandom_range(0, 99) < 35);
      md   = 4'($urandom_range(0, 3));
      mdat = 8'($urandom);
      rs   = ($urandom_range(0, 99) >= 2);
      cycle(rs, av, ad, adat, mv, md, mdat, 4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)));
    end
    for (int n = 0; n < 4; n++) idle(4'd0, 4'd1);
    chk("sb_empty", 8'(sb.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
